// File: rtl/inst_fetch_unit_if.sv
// Bus bundle for inst_fetch_unit: the instruction-memory request/response
// channel, the decode valid/ready channel, redirect input and fetch counter.
// The master modport is the fetch unit; the slave modport is its environment
// (instruction memory, decode and branch unit).
interface inst_fetch_unit_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INST_W = 32
);
    logic              o_imem_valid;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_valid;
    logic [INST_W-1:0] i_imem_inst;
    logic              o_inst_valid;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_inst_pc;
    logic              i_inst_ready;
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;
    logic [31:0]       o_fetch_cnt;

    modport master (
        output o_imem_valid, o_imem_addr,
        input  i_imem_valid, i_imem_inst,
        output o_inst_valid, o_inst, o_inst_pc,
        input  i_inst_ready, i_redirect, i_redirect_pc,
        output o_fetch_cnt
    );

    modport slave (
        input  o_imem_valid, o_imem_addr,
        output i_imem_valid, i_imem_inst,
        input  o_inst_valid, o_inst, o_inst_pc,
        output i_inst_ready, i_redirect, i_redirect_pc,
        input  o_fetch_cnt
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage. Holds the PC, issues one single-cycle read request
// at a time to instruction memory, buffers the returned word and offers it to
// decode over valid/ready. A redirect squashes in-flight and buffered fetches.
//
// state | meaning
// ------+-----------------------------------------------------------------
// REQ   | after reset: issue the first request from pc (nothing in flight)
// WAIT  | request issued (o_imem_valid high in the first WAIT cycle),
//       | waiting for the memory response
// HOLD  | instruction buffered and presented to decode until accepted
// DRAIN | a squashed request is in flight; discard its response
//
// Every transition that leaves for a new fetch issues the request in the
// same edge (registered o_imem_valid/o_imem_addr) and lands in WAIT, which
// gives the 3-cycle REQ/WAIT/HOLD cadence with decode always ready. REQ is
// therefore only ever occupied straight out of reset; a redirect there just
// retargets the pending first request since nothing has been issued yet.
module inst_fetch_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    inst_fetch_unit_if.master bus
);

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              imem_valid_q, imem_valid_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;

    logic              issue;
    logic [ADDR_W-1:0] issue_pc;
    logic [ADDR_W-1:0] redirect_pc;
    logic              handshake;

    // Next-state logic: redirect first, then the normal fetch sequence;
    // any new request is launched through the common issue path at the end.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        imem_valid_d = 1'b0;
        imem_addr_d  = imem_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fetch_cnt_d  = fetch_cnt_q;
        issue        = 1'b0;
        issue_pc     = pc_q;
        redirect_pc  = bus.i_redirect_pc & ALIGN_MASK;
        // inst_valid_q is only ever high in HOLD
        handshake    = inst_valid_q & bus.i_inst_ready;

        if (handshake) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end

        if (bus.i_redirect) begin
            pc_d         = redirect_pc;
            inst_valid_d = 1'b0;
            unique case (state_q)
                ST_REQ: state_d = ST_REQ;
                ST_WAIT: begin
                    if (bus.i_imem_valid) begin
                        issue    = 1'b1;
                        issue_pc = redirect_pc;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    issue    = 1'b1;
                    issue_pc = redirect_pc;
                end
                ST_DRAIN: begin
                    if (bus.i_imem_valid) begin
                        issue    = 1'b1;
                        issue_pc = redirect_pc;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    issue    = 1'b1;
                    issue_pc = pc_q;
                end
                ST_WAIT: begin
                    if (bus.i_imem_valid) begin
                        inst_d       = bus.i_imem_inst;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        inst_valid_d = 1'b0;
                        issue        = 1'b1;
                        issue_pc     = pc_q + PC_STEP;
                    end
                end
                ST_DRAIN: begin
                    if (bus.i_imem_valid) begin
                        issue    = 1'b1;
                        issue_pc = pc_q;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end

        if (issue) begin
            pc_d         = issue_pc;
            imem_valid_d = 1'b1;
            imem_addr_d  = issue_pc;
            state_d      = ST_WAIT;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_REQ;
            pc_q         <= PC_INIT;
            imem_valid_q <= 1'b0;
            imem_addr_q  <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_valid_q <= imem_valid_d;
            imem_addr_q  <= imem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign bus.o_imem_valid = imem_valid_q;
    assign bus.o_imem_addr  = imem_addr_q;
    assign bus.o_inst_valid = inst_valid_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_inst_pc    = inst_pc_q;
    assign bus.o_fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit. A memory model answers each request one cycle
// after it is seen; a scoreboard queues requested addresses and checks every
// instruction decode accepts, and a fetch-count model tracks handshakes.
module tb_inst_fetch_unit;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INST_W = 32;
    localparam logic [63:0] PC_A = 64'h100;
    localparam logic [63:0] PC_B = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk;
    logic rst_n;

    inst_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus_a ();
    inst_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus_b ();

    inst_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(PC_A)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    inst_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(PC_B)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        s_iv, s_v;
    logic [63:0] s_ia, s_pc;
    logic [31:0] s_inst, s_cnt;

    logic [63:0] sb_q[$];
    logic [31:0] cnt_model = 0;
    logic        mem_pend = 1'b0;
    logic [63:0] mem_pend_addr = '0;

    logic [63:0] b_addrs[$];

    typedef struct {
        logic        rdy;
        logic        iv;
        logic [63:0] ia;
        logic        v;
        logic [63:0] pc;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hA500_0000 ^ a[31:0] ^ a[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle on dut_a: sample outputs at negedge, score them, then drive
    // the memory response and decode/redirect inputs for the next edge.
    task automatic step(input logic rdy, input logic redir, input logic [63:0] rpc);
        logic        resp;
        logic [63:0] resp_addr;
        logic [63:0] e;
        @(negedge clk);
        s_iv   = bus_a.o_imem_valid;
        s_ia   = bus_a.o_imem_addr;
        s_v    = bus_a.o_inst_valid;
        s_inst = bus_a.o_inst;
        s_pc   = bus_a.o_inst_pc;
        s_cnt  = bus_a.o_fetch_cnt;

        check("fetch_cnt", {32'd0, s_cnt}, {32'd0, cnt_model});
        if (s_v && rdy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_inst_pc", s_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_inst_pc", s_pc, e);
                check("sb_inst", {32'd0, s_inst}, {32'd0, mem_word(e)});
            end
            cnt_model = cnt_model + 32'd1;
        end
        if (s_iv) sb_q.push_back(s_ia);
        if (redir) sb_q.delete();

        resp          = mem_pend;
        resp_addr     = mem_pend_addr;
        mem_pend      = s_iv;
        mem_pend_addr = s_ia;
        bus_a.i_imem_valid  = resp;
        bus_a.i_imem_inst   = resp ? mem_word(resp_addr) : 32'd0;
        bus_a.i_inst_ready  = rdy;
        bus_a.i_redirect    = redir;
        bus_a.i_redirect_pc = rpc;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_imem_valid"}, {63'd0, bus_a.o_imem_valid}, 64'd0);
        check({tag, "_imem_addr"},  bus_a.o_imem_addr, 64'd0);
        check({tag, "_inst_valid"}, {63'd0, bus_a.o_inst_valid}, 64'd0);
        check({tag, "_inst"},       {32'd0, bus_a.o_inst}, 64'd0);
        check({tag, "_inst_pc"},    bus_a.o_inst_pc, 64'd0);
        check({tag, "_fetch_cnt"},  {32'd0, bus_a.o_fetch_cnt}, 64'd0);
    endtask

    // Memory and decode environment for dut_b (decode always ready).
    initial begin
        logic        pend;
        logic [63:0] paddr;
        pend = 1'b0;
        paddr = '0;
        bus_b.i_imem_valid  = 1'b0;
        bus_b.i_imem_inst   = '0;
        bus_b.i_inst_ready  = 1'b1;
        bus_b.i_redirect    = 1'b0;
        bus_b.i_redirect_pc = '0;
        forever begin
            @(negedge clk);
            bus_b.i_imem_valid = pend;
            bus_b.i_imem_inst  = mem_word(paddr);
            pend  = bus_b.o_imem_valid;
            paddr = bus_b.o_imem_addr;
            if (bus_b.o_imem_valid && b_addrs.size() < 4) b_addrs.push_back(bus_b.o_imem_addr);
        end
    end

    initial begin
        logic [31:0] h_inst;
        logic [63:0] h_pc;
        logic [31:0] c0;

        tbl[0] = '{1'b1, 1'b1, 64'h100, 1'b0, 64'h0,   32'd0};
        tbl[1] = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   32'd0};
        tbl[2] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h100, 32'd0};
        tbl[3] = '{1'b1, 1'b1, 64'h104, 1'b0, 64'h0,   32'd1};
        tbl[4] = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   32'd1};
        tbl[5] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h104, 32'd1};
        tbl[6] = '{1'b1, 1'b1, 64'h108, 1'b0, 64'h0,   32'd2};
        tbl[7] = '{1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   32'd2};
        tbl[8] = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h108, 32'd2};
        tbl[9] = '{1'b1, 1'b1, 64'h10C, 1'b0, 64'h0,   32'd3};

        rst_n = 1'b0;
        bus_a.i_imem_valid  = 1'b0;
        bus_a.i_imem_inst   = '0;
        bus_a.i_inst_ready  = 1'b0;
        bus_a.i_redirect    = 1'b0;
        bus_a.i_redirect_pc = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Basic fetch cadence from reset, decode always ready.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rdy, 1'b0, 64'd0);
            check($sformatf("t1_imem_valid[%0d]", i), {63'd0, s_iv}, {63'd0, tbl[i].iv});
            if (tbl[i].iv) check($sformatf("t1_imem_addr[%0d]", i), s_ia, tbl[i].ia);
            check($sformatf("t1_inst_valid[%0d]", i), {63'd0, s_v}, {63'd0, tbl[i].v});
            if (tbl[i].v) check($sformatf("t1_inst_pc[%0d]", i), s_pc, tbl[i].pc);
            check($sformatf("t1_fetch_cnt[%0d]", i), {32'd0, s_cnt}, {32'd0, tbl[i].cnt});
        end

        // Backpressure: hold 5 cycles, then accept.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 64'd0);
            if (s_v) break;
        end
        check("t2_inst_valid_seen", {63'd0, s_v}, 64'd1);
        h_inst = s_inst;
        h_pc   = s_pc;
        check("t2_hold_pc", h_pc, 64'h10C);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 64'd0);
            check("t2_hold_valid", {63'd0, s_v}, 64'd1);
            check("t2_hold_inst", {32'd0, s_inst}, {32'd0, h_inst});
            check("t2_hold_pc_stable", s_pc, h_pc);
            check("t2_no_request", {63'd0, s_iv}, 64'd0);
        end
        step(1'b1, 1'b0, 64'd0);
        step(1'b1, 1'b0, 64'd0);
        check("t2_next_req_valid", {63'd0, s_iv}, 64'd1);
        check("t2_next_req_addr", s_ia, h_pc + 64'd4);
        check("t2_inst_valid_low", {63'd0, s_v}, 64'd0);

        // Redirect on the cycle the request to 0x10 is visible.
        step(1'b0, 1'b1, 64'h10);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 64'd0);
            if (s_iv && s_ia == 64'h10) break;
        end
        check("t3_req_0x10", s_ia, 64'h10);
        c0 = cnt_model;
        step(1'b0, 1'b1, 64'h203);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 64'd0);
            if (s_v) check("t3_squashed_pc_shown", s_pc, 64'h200);
            if (s_iv) break;
        end
        check("t3_next_req_addr", s_ia, 64'h200);
        check("t3_cnt_unchanged", {32'd0, s_cnt}, {32'd0, c0});

        // Redirect in HOLD with decode not ready: buffered inst dropped.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 64'd0);
            if (s_v) break;
        end
        check("t4_hold_pc", s_pc, 64'h200);
        c0 = cnt_model;
        step(1'b0, 1'b1, 64'h300);
        step(1'b0, 1'b0, 64'd0);
        check("t4_valid_fell", {63'd0, s_v}, 64'd0);
        check("t4_req_valid", {63'd0, s_iv}, 64'd1);
        check("t4_req_addr", s_ia, 64'h300);
        check("t4_cnt_same", {32'd0, s_cnt}, {32'd0, c0});

        // Redirect in HOLD with decode ready: handshake still counts.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 64'd0);
            if (s_v) break;
        end
        check("t4b_hold_pc", s_pc, 64'h300);
        step(1'b1, 1'b1, 64'h400);
        step(1'b0, 1'b0, 64'd0);
        check("t4b_cnt_plus1", {32'd0, s_cnt}, {32'd0, c0 + 32'd1});
        check("t4b_valid_low", {63'd0, s_v}, 64'd0);
        check("t4b_req_addr", s_iv ? s_ia : 64'hDEAD, 64'h400);

        // PC wrap on dut_b.
        check("t5_b_req_count", 64'(b_addrs.size() >= 2), 64'd1);
        if (b_addrs.size() >= 2) begin
            check("t5_b_first_addr", b_addrs[0], PC_B);
            check("t5_b_wrap_addr", b_addrs[1], 64'h0);
        end

        // Reset during WAIT, then a stray response right after release.
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 64'd0);
            if (s_iv) break;
        end
        check("t6_in_wait", {63'd0, s_iv}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("t6_reset");
        sb_q.delete();
        cnt_model = 0;
        mem_pend  = 1'b0;
        bus_a.i_imem_valid = 1'b0;
        bus_a.i_inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        bus_a.i_imem_valid = 1'b1;
        bus_a.i_imem_inst  = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 64'd0);
        check("t6_first_req_valid", {63'd0, s_iv}, 64'd1);
        check("t6_first_req_addr", s_ia, PC_A);
        check("t6_no_inst", {63'd0, s_v}, 64'd0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 64'd0);
            if (s_v) break;
        end
        check("t6_inst_valid", {63'd0, s_v}, 64'd1);
        check("t6_inst_word", {32'd0, s_inst}, {32'd0, mem_word(PC_A)});
        step(1'b0, 1'b0, 64'd0);
        check("t6_cnt_one", {32'd0, s_cnt}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
